// File: rtl/pet_video_gen_if.sv
// Fetch bus between the raster generator and video RAM / character ROM.
// The generator drives the addresses; the memories answer combinationally.
interface pet_video_gen_if #(
    parameter int VRAM_AW = 11
);
    logic [VRAM_AW-1:0] video_addr;
    logic [7:0]         video_data;
    logic [10:0]        charaddr;
    logic [7:0]         chardata;
    logic               video_gfx;

    modport master (
        output video_addr,
        output charaddr,
        input  video_data,
        input  chardata,
        input  video_gfx
    );

    modport slave (
        input  video_addr,
        input  charaddr,
        output video_data,
        output chardata,
        output video_gfx
    );
endinterface

// File: rtl/pet_video_gen.sv
// PET-style text raster generator: 40/80 columns, 8..16-line cells, scroll.
// Optional PET_VIDEO_REVERSE_EN adds reverse_all (whole-screen inversion).
module pet_video_gen #(
    parameter int COLS     = 40,
    parameter int ROWS     = 25,
    parameter int CHAR_H   = 8,
    parameter int H_TOTAL  = 448,
    parameter int V_TOTAL  = 262,
    parameter int HS_START = 358,
    parameter int HS_END   = 391,
    parameter int VS_START = 225,
    parameter int VS_END   = 234,
    parameter int VRAM_AW  = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce_pixp,
    input  logic               ce_pixn,
    input  logic [VRAM_AW-1:0] start_addr,
    pet_video_gen_if.master    mem,
    input  logic               video_blank,
`ifdef PET_VIDEO_REVERSE_EN
    input  logic               reverse_all,
`endif
    output logic               video_on,
    output logic               pix,
    output logic               HSync,
    output logic               VSync,
    output logic               HBlank,
    output logic               VBlank
);
    localparam int HW   = $clog2(H_TOTAL);
    localparam int VW   = $clog2(V_TOTAL);
    localparam int HACT = COLS * 8;
    localparam int VACT = ROWS * CHAR_H;

    logic [HW-1:0]      hc;
    logic [VW-1:0]      vc;
    logic [3:0]         line;
    logic [VRAM_AW-1:0] row_base;
    logic [7:0]         vdata;
    logic               inv;

    logic hc_end;
    logic vc_end;
    logic line_end;
    logic h_act;
    logic v_act;
    logic load_ok;

    assign hc_end   = (hc == HW'(H_TOTAL - 1));
    assign vc_end   = (vc == VW'(V_TOTAL - 1));
    assign line_end = (line == 4'(CHAR_H - 1));
    assign h_act    = (hc < HW'(HACT));
    assign v_act    = (vc < VW'(VACT));
    // Font rows beyond 8 are padding scanlines with no pattern data.
    assign load_ok  = h_act && v_act && !line[3];

    assign video_on       = v_act;
    assign mem.video_addr = row_base + VRAM_AW'(hc >> 3);
    assign mem.charaddr   = {mem.video_gfx, mem.video_data[6:0], line[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            hc       <= '0;
            vc       <= '0;
            line     <= '0;
            row_base <= start_addr;
        end else if (ce_pixp) begin
            if (hc_end) begin
                hc <= '0;
                if (vc_end) begin
                    vc       <= '0;
                    line     <= '0;
                    row_base <= start_addr;
                end else begin
                    vc <= vc + 1'b1;
                    if (line_end) begin
                        line     <= '0;
                        row_base <= row_base + VRAM_AW'(COLS);
                    end else begin
                        line <= line + 1'b1;
                    end
                end
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vdata  <= '0;
            inv    <= 1'b0;
            HSync  <= 1'b0;
            VSync  <= 1'b0;
            HBlank <= 1'b1;
            VBlank <= 1'b1;
        end else if (ce_pixn) begin
            if (hc[2:0] == 3'd0) begin
                if (load_ok) begin
                    inv   <= mem.video_data[7];
                    vdata <= mem.chardata;
                end else begin
                    inv   <= 1'b0;
                    vdata <= '0;
                end
                HBlank <= !h_act;
                VBlank <= !v_act;
            end else begin
                vdata <= {vdata[6:0], 1'b0};
            end
            if (hc == HW'(HS_START)) begin
                HSync <= 1'b1;
                if (vc == VW'(VS_START)) begin
                    VSync <= 1'b1;
                end else if (vc == VW'(VS_END)) begin
                    VSync <= 1'b0;
                end
            end else if (hc == HW'(HS_END)) begin
                HSync <= 1'b0;
            end
        end
    end

    logic pix_raw;
    assign pix_raw = vdata[7] ^ inv;

`ifdef PET_VIDEO_REVERSE_EN
    logic rev_q;

    // Latched once per frame so the whole picture flips at a clean boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            rev_q <= 1'b0;
        end else if (ce_pixp && hc_end && vc_end) begin
            rev_q <= reverse_all;
        end
    end

    assign pix = rev_q
        ? (~pix_raw & ~video_blank & ~HBlank & ~VBlank)
        : (pix_raw & ~video_blank);
`else
    assign pix = pix_raw & ~video_blank;
`endif

endmodule

// File: tb/tb_pet_video_gen.sv
// Directed bench for pet_video_gen: three instances share one pixel stream.
// Default timing, a short 40-col frame and an 80-col / 10-line-cell variant.
module tb_pet_video_gen;
    logic clk;
    logic reset;
    logic ce_pixp;
    logic ce_pixn;
    logic blank_d;
    logic [10:0] start_d;
    logic [10:0] start_a;
    logic [10:0] start_b;

    logic on_d, pix_d, hs_d, vs_d, hb_d, vb_d;
    logic on_a, pix_a, hs_a, vs_a, hb_a, vb_a;
    logic on_b, pix_b, hs_b, vs_b, hb_b, vb_b;

    pet_video_gen_if bus_d ();
    pet_video_gen_if bus_a ();
    pet_video_gen_if bus_b ();

    assign bus_d.video_data = 8'h81;
    assign bus_d.chardata   = 8'hA5;
    assign bus_d.video_gfx  = 1'b0;
    assign bus_a.video_data = 8'h20;
    assign bus_a.chardata   = 8'h00;
    assign bus_a.video_gfx  = 1'b0;
    assign bus_b.video_data = 8'h00;
    assign bus_b.chardata   = 8'hFF;
    assign bus_b.video_gfx  = 1'b0;

    pet_video_gen u_d (
        .clk(clk), .reset(reset),
        .ce_pixp(ce_pixp), .ce_pixn(ce_pixn),
        .start_addr(start_d), .mem(bus_d),
        .video_blank(blank_d),
`ifdef PET_VIDEO_REVERSE_EN
        .reverse_all(1'b0),
`endif
        .video_on(on_d), .pix(pix_d),
        .HSync(hs_d), .VSync(vs_d),
        .HBlank(hb_d), .VBlank(vb_d)
    );

    pet_video_gen #(
        .COLS(40), .ROWS(4), .CHAR_H(8),
        .H_TOTAL(336), .V_TOTAL(36),
        .HS_START(324), .HS_END(330),
        .VS_START(33), .VS_END(35)
    ) u_a (
        .clk(clk), .reset(reset),
        .ce_pixp(ce_pixp), .ce_pixn(ce_pixn),
        .start_addr(start_a), .mem(bus_a),
        .video_blank(1'b0),
`ifdef PET_VIDEO_REVERSE_EN
        .reverse_all(1'b0),
`endif
        .video_on(on_a), .pix(pix_a),
        .HSync(hs_a), .VSync(vs_a),
        .HBlank(hb_a), .VBlank(vb_a)
    );

    pet_video_gen #(
        .COLS(80), .ROWS(3), .CHAR_H(10),
        .H_TOTAL(648), .V_TOTAL(34),
        .HS_START(644), .HS_END(646),
        .VS_START(31), .VS_END(33)
    ) u_b (
        .clk(clk), .reset(reset),
        .ce_pixp(ce_pixp), .ce_pixn(ce_pixn),
        .start_addr(start_b), .mem(bus_b),
        .video_blank(1'b0),
`ifdef PET_VIDEO_REVERSE_EN
        .reverse_all(1'b0),
`endif
        .video_on(on_b), .pix(pix_b),
        .HSync(hs_b), .VSync(vs_b),
        .HBlank(hb_b), .VBlank(vb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;
    int pos;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half(input bit p);
        if (p) ce_pixp = 1'b1;
        else   ce_pixn = 1'b1;
        @(posedge clk);
        #1;
        ce_pixp = 1'b0;
        ce_pixn = 1'b0;
    endtask

    task automatic goto(input int p);
        while (pos < p) begin
            half(1'b1);
            pos++;
            half(1'b0);
        end
    endtask

    logic [7:0] exp_pat;
    logic acc;

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        pos     = 0;
        reset   = 1'b1;
        ce_pixp = 1'b0;
        ce_pixn = 1'b0;
        blank_d = 1'b0;
        start_d = 11'h000;
        start_a = 11'h000;
        start_b = 11'h000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_hblank", hb_d, 1);
        check("rst_vblank", vb_d, 1);
        check("rst_hsync", hs_d, 0);
        check("rst_vsync", vs_d, 0);
        check("rst_pix", pix_d, 0);
        check("rst_addr_d", bus_d.video_addr, 0);
        check("rst_on_d", on_d, 1);

        half(1'b0);
        check("hblank_clr", hb_d, 0);
        check("vblank_clr", vb_d, 0);

        // 0x81 / 0xA5: reverse bit set, so 0xA5 appears inverted.
        exp_pat = 8'b0101_1010;
        for (int k = 0; k < 8; k++) begin
            goto(k);
            check($sformatf("pix_%0d", k), pix_d, exp_pat[7-k]);
        end
        blank_d = 1'b1;
        for (int k = 8; k < 16; k++) begin
            goto(k);
            check($sformatf("pix_blank_%0d", k), pix_d, 0);
        end
        blank_d = 1'b0;

        goto(319); check("hblank_319", hb_d, 0);
        goto(320); check("hblank_320", hb_d, 1);
        goto(323); check("a_hs_323", hs_a, 0);
        goto(324); check("a_hs_324", hs_a, 1);
        goto(329); check("a_hs_329", hs_a, 1);
        goto(330); check("a_hs_330", hs_a, 0);
        check("pix_hblank", pix_d, 0);
        goto(357); check("hs_357", hs_d, 0);
        goto(358); check("hs_358", hs_d, 1);
        goto(390); check("hs_390", hs_d, 1);
        goto(391); check("hs_391", hs_d, 0);

        goto(2704);
        check("a_addr_l8", bus_a.video_addr, 42);

        goto(6720);
        start_a = 11'h7F0;
        goto(6736);
        check("a_addr_hold", bus_a.video_addr, 82);

        goto(10416);
        check("a_vblank_31", vb_a, 0);
        check("a_on_31", on_a, 1);
        goto(10752);
        check("a_vblank_32", vb_a, 1);
        check("a_on_32", on_a, 0);

        goto(11411); check("a_vs_pre", vs_a, 0);
        goto(11412); check("a_vs_set", vs_a, 1);
        goto(12083); check("a_vs_hold", vs_a, 1);
        goto(12084); check("a_vs_clr", vs_a, 0);

        goto(12095);
        check("a_addr_last", bus_a.video_addr, 201);
        goto(12096);
        check("a_addr_new", bus_a.video_addr, 11'h7F0);
        goto(12216);
        check("a_addr_7ff", bus_a.video_addr, 11'h7FF);
        goto(12224);
        check("a_addr_wrap", bus_a.video_addr, 11'h000);
        goto(14800);
        check("a_addr_f2l8", bus_a.video_addr, 11'h01A);

        goto(16216);
        check("b_addr", bus_b.video_addr, 162);
        check("b_charaddr", bus_b.charaddr, 5);
        goto(17496);
        check("b_pix_l7", pix_b, 1);
        acc = 1'b0;
        for (int p = 18144; p < 18144 + 640; p++) begin
            goto(p);
            acc = acc | pix_b;
        end
        check("b_pix_l8", acc, 0);

        goto(19186);
        check("pre_rst_hs", hs_d, 1);
        check("pre_rst_hb", hb_d, 1);
        check("pre_rst_vb_a", vb_a, 0);
        reset = 1'b1;
        half(1'b1);
        half(1'b0);
        reset = 1'b0;
        pos = 0;
        check("mid_rst_hs", hs_d, 0);
        check("mid_rst_vs", vs_d, 0);
        check("mid_rst_hb", hb_d, 1);
        check("mid_rst_vb", vb_d, 1);
        check("mid_rst_vb_a", vb_a, 1);
        check("mid_rst_addr", bus_d.video_addr, 0);
        check("mid_rst_addr_a", bus_a.video_addr, 11'h7F0);
        half(1'b0);
        check("post_rst_hb", hb_d, 0);
        goto(16);
        check("post_rst_addr", bus_d.video_addr, 2);
        check("post_rst_addr_a", bus_a.video_addr, 11'h7F2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pet_video_gen.md
Name: pet_video_gen

Overview:
- Parametrised successor to the PET 40-column raster generator.
- Supports 40- or 80-column text, and any character cell height from 8 to 16 scanlines.
- Adds a runtime screen start address (hardware scroll) with VRAM wrap-around.
- Sits between video RAM / character ROM and the scaler. Outputs 1-bit pixel, syncs and blanks.

Parameters:
- COLS, 40, characters per row (40 or 80).
- ROWS, 25, character rows per frame.
- CHAR_H, 8, scanlines per character cell (8..16); font supplies 8 lines, lines 8..CHAR_H-1 are blank.
- H_TOTAL, 448, pixel clocks per line (must exceed COLS*8).
- V_TOTAL, 262, lines per frame (must exceed ROWS*CHAR_H).
- HS_START, 358, HS_END, 391, HSync assert/deassert hc values.
- VS_START, 225, VS_END, 234, VSync assert/deassert line numbers.
- VRAM_AW, 11, video RAM address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_pixp  in  1  pixel clock enable, counter phase
- ce_pixn  in  1  pixel clock enable, output phase (never coincident with ce_pixp)
- start_addr  in  VRAM_AW  screen start address in VRAM
- video_addr  out  VRAM_AW  VRAM fetch address
- video_data  in  8  VRAM data (bit 7 = reverse)
- charaddr  out  11  char ROM address {video_gfx, code[6:0], line[2:0]}
- chardata  in  8  char ROM data, MSB = leftmost pixel
- video_gfx  in  1  char set select
- video_blank  in  1  force pixel off
- video_on  out  1  high during active rows (vc < ROWS*CHAR_H)
- pix  out  1  pixel
- HSync, VSync, HBlank, VBlank  out  1  timing

Behaviour:
- Counters advance on ce_pixp only:
  - hc: 0..H_TOTAL-1.
  - At hc==H_TOTAL-1: hc<=0, vc increments, line increments.
  - When line==CHAR_H-1: line<=0, row increments, row_base<=row_base+COLS.
  - At vc==V_TOTAL-1 and line end: vc, row and line <= 0, and row_base<=start_addr.
- start_addr is sampled only at frame wrap; changes mid-frame take effect next frame.
- Address arithmetic:
  - video_addr = row_base + hc/8, truncated mod 2^VRAM_AW.
  - Wraps from 2^VRAM_AW-1 to 0 within a row.
  - No multiplier or divider; row_base is accumulated.
- charaddr line field = line[2:0]. When line>=8, the loaded pattern is forced to 0.
- Pixel pipeline on ce_pixn:
  - If hc[2:0]==0: load {inv, vdata} <= {video_data[7], chardata} when hc<COLS*8, vc<ROWS*CHAR_H and line<8; else load 0.
  - Same edge: HBlank <= (hc>=COLS*8), VBlank <= (vc>=ROWS*CHAR_H).
  - Otherwise vdata shifts left, filling with 0.
- pix = (vdata[7] ^ inv) & ~video_blank, combinational.
- Sync on ce_pixn:
  - HSync<=1 at hc==HS_START, HSync<=0 at hc==HS_END.
  - At hc==HS_START: VSync<=1 if vc==VS_START, VSync<=0 if vc==VS_END.
- Reset values:
  - hc, vc, row, line = 0; row_base = start_addr.
  - vdata and inv = 0; HSync and VSync = 0; HBlank and VBlank = 1.
- Reset mid-frame restarts at line 0, pixel 0 on the next ce_pixp.
- Reset has priority over both enables.
- Latency: VRAM/ROM data must be valid combinationally by the ce_pixn following the ce_pixp that set hc[2:0]==0.

Optional Feature:
- Macro: PET_VIDEO_REVERSE_EN.
- Defined: adds input port reverse_all (1 bit), sampled at frame wrap. When set, pix = ~(vdata[7]^inv) & ~video_blank & ~HBlank & ~VBlank, so the active area is inverted and blanking stays 0.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
- Reset, defaults, count to hc=447 and vc=261 -> hc wraps to 0 and vc to 0. HSync high for hc 358..390. VSync high for lines 225..233. HBlank rises at hc=320; VBlank rises at line 200.
- start_addr=0x000, line 8 (row 1), hc=16 -> video_addr=42.
- COLS=80, CHAR_H=10, line 25 (row 2, line 5) -> video_addr=162, charaddr[2:0]=5. Line 28 (line 8) -> pix=0 across the whole row.
- start_addr=0x7F0, row 0, hc=128 (col 16) -> video_addr=0x000 (wrap).
- Change start_addr at vc=100 -> video_addr unchanged until the next frame, then follows the new base.
- video_data=0x81, chardata=0xA5 -> pix sequence 0,1,0,1,1,0,1,0. With video_blank=1 -> all 0.
- Reset asserted at vc=150, hc=200 -> next cycle hc=0, vc=0, HBlank=1, VBlank=1, HSync=0, VSync=0.
